fir_tap_sched: RTL and testbench

Sequencing controller for an 11-tap FIR built around two `bram11` instances: tap RAM holding coefficients and data RAM holding a circular window of input samples. It arbitrates the tap RAM between configuration access (idle only) and the MAC engine. It clears the data window, accepts samples over a stream handshake and runs an 11-cycle multiply-accumulate per sample. Results go out on a stream handshake with a last marker.

---
 rtl/fir_sched_pkg.sv | 24 ++
 rtl/fir_mac.sv | 33 +++
 rtl/fir_tap_sched.sv | 193 +++++++++++++++++++
 tb/tb_fir_tap_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared state encoding, sizing constants and ring-index helper for the
// 11-tap FIR sequencing controller.
package fir_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  localparam int TAPS       = 11;
  localparam int IDX_W      = 4;
  localparam int WORD_SHIFT = 2;

  // Step one position backwards around a ring of 'depth' words.
  function automatic logic [IDX_W-1:0] circDec(input logic [IDX_W-1:0] idx,
                                               input int depth);
    return (idx == '0) ? IDX_W'(depth - 1) : idx - 1'b1;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply-accumulate: synchronous clear, enable-gated accumulate,
// result wraps modulo 2**BIT_WIDTH.
module fir_mac #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic [BIT_WIDTH-1:0] acc
);

  // Only the low word of the product is kept, and those bits are identical
  // for signed and unsigned operands, so a plain multiply is sufficient.
  logic [BIT_WIDTH-1:0] w_prod;
  logic [BIT_WIDTH-1:0] r_acc;

  assign w_prod = a * b;
  assign acc    = r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod;
    end
  end

endmodule

// File: rtl/fir_tap_sched.sv
// Sequencing controller for an 11-tap FIR: arbitrates the tap RAM, clears and
// fills the circular data window, and runs one MAC pass per input sample.
module fir_tap_sched #(
  parameter int ADDR_WIDTH = 12,
  parameter int TAPS       = fir_sched_pkg::TAPS,
  parameter int BIT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ap_start,
  input  logic [31:0]           data_len,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic                  cfg_we,
  input  logic                  cfg_re,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [BIT_WIDTH-1:0]  cfg_wdata,
  output logic [BIT_WIDTH-1:0]  cfg_rdata,
  input  logic                  ss_valid,
  input  logic [BIT_WIDTH-1:0]  ss_data,
  output logic                  ss_ready,
  output logic                  sm_valid,
  output logic [BIT_WIDTH-1:0]  sm_data,
  output logic                  sm_last,
  input  logic                  sm_ready,
  output logic                  tap_we,
  output logic                  tap_re,
  output logic [ADDR_WIDTH-1:0] tap_waddr,
  output logic [ADDR_WIDTH-1:0] tap_raddr,
  output logic [BIT_WIDTH-1:0]  tap_wdi,
  input  logic [BIT_WIDTH-1:0]  tap_rdo,
  output logic                  data_we,
  output logic                  data_re,
  output logic [ADDR_WIDTH-1:0] data_waddr,
  output logic [ADDR_WIDTH-1:0] data_raddr,
  output logic [BIT_WIDTH-1:0]  data_wdi,
  input  logic [BIT_WIDTH-1:0]  data_rdo
);
  import fir_sched_pkg::*;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_wptr;
  logic [IDX_W-1:0] r_dptr;
  logic [31:0]      r_count;
  logic [31:0]      r_len;
  logic             r_rdValid;
  logic             r_cfgRdPend;
  logic             r_apIdle;
  logic             r_apDone;
  logic             r_ssReady;
  logic             r_smValid;
  logic             r_smLast;

  logic             w_isIdle;
  logic             w_cfgInRange;
  logic             w_cfgWe;
  logic             w_cfgRe;
  logic             w_macIssue;
  logic             w_inHs;
  logic             w_outHs;
  logic [BIT_WIDTH-1:0] w_acc;

  assign w_isIdle     = (r_state == S_IDLE);
  assign w_cfgInRange = (cfg_addr >> WORD_SHIFT) < ADDR_WIDTH'(TAPS);
  assign w_cfgWe      = cfg_we && w_isIdle && w_cfgInRange;
  assign w_cfgRe      = cfg_re && w_isIdle && w_cfgInRange;
  assign w_macIssue   = (r_state == S_MAC) && (r_idx < IDX_W'(TAPS));
  assign w_inHs       = ss_valid && r_ssReady;
  assign w_outHs      = r_smValid && sm_ready;

  // Configuration owns the tap port only while idle; the MAC pass owns it otherwise.
  assign tap_we     = w_cfgWe;
  assign tap_waddr  = cfg_addr;
  assign tap_wdi    = cfg_wdata;
  assign tap_re     = w_cfgRe || w_macIssue;
  assign tap_raddr  = w_macIssue ? (ADDR_WIDTH'(r_idx) << WORD_SHIFT) : cfg_addr;

  assign data_we    = (r_state == S_CLEAR) || w_inHs;
  assign data_waddr = (r_state == S_CLEAR) ? (ADDR_WIDTH'(r_idx) << WORD_SHIFT)
                                           : (ADDR_WIDTH'(r_wptr) << WORD_SHIFT);
  assign data_wdi   = w_inHs ? ss_data : '0;
  assign data_re    = w_macIssue;
  assign data_raddr = ADDR_WIDTH'(r_dptr) << WORD_SHIFT;

  assign cfg_rdata  = r_cfgRdPend ? tap_rdo : '0;
  assign ap_idle    = r_apIdle;
  assign ap_done    = r_apDone;
  assign ss_ready   = r_ssReady;
  assign sm_valid   = r_smValid;
  assign sm_data    = w_acc;
  assign sm_last    = r_smLast;

  fir_mac #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clear(w_inHs),
    .en   (r_rdValid),
    .a    (tap_rdo),
    .b    (data_rdo),
    .acc  (w_acc)
  );

  // RAM data arrives one cycle after each issue, so accumulation trails by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wptr      <= '0;
      r_dptr      <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_rdValid   <= 1'b0;
      r_cfgRdPend <= 1'b0;
      r_apIdle    <= 1'b1;
      r_apDone    <= 1'b0;
      r_ssReady   <= 1'b0;
      r_smValid   <= 1'b0;
      r_smLast    <= 1'b0;
    end else begin
      r_apDone    <= 1'b0;
      r_rdValid   <= w_macIssue;
      r_cfgRdPend <= w_cfgRe;
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_len    <= data_len;
            r_wptr   <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_apIdle <= 1'b0;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_idx == IDX_W'(TAPS - 1)) begin
            r_idx <= '0;
            if (r_len == 32'd0) begin
              r_apDone <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_ssReady <= 1'b1;
              r_state   <= S_WAIT_IN;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_WAIT_IN: begin
          if (w_inHs) begin
            r_ssReady <= 1'b0;
            r_dptr    <= r_wptr;
            r_idx     <= '0;
            r_state   <= S_MAC;
          end
        end
        S_MAC: begin
          if (w_macIssue) begin
            r_idx  <= r_idx + 1'b1;
            r_dptr <= circDec(r_dptr, TAPS);
          end else begin
            r_wptr    <= (r_wptr == IDX_W'(TAPS - 1)) ? '0 : r_wptr + 1'b1;
            r_count   <= r_count + 32'd1;
            r_smValid <= 1'b1;
            r_smLast  <= (r_count + 32'd1) == r_len;
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (w_outHs) begin
            r_smValid <= 1'b0;
            r_smLast  <= 1'b0;
            if (r_smLast) begin
              r_apDone <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_ssReady <= 1'b1;
              r_state   <= S_WAIT_IN;
            end
          end
        end
        S_DONE: begin
          r_apIdle <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sched.sv
// Directed self-checking bench for fir_tap_sched with behavioural tap/data RAMs.
module tb_fir_tap_sched;

  logic        clk;
  logic        rst;
  logic        ap_start;
  logic [31:0] data_len;
  logic        ap_idle;
  logic        ap_done;
  logic        cfg_we;
  logic        cfg_re;
  logic [11:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        ss_valid;
  logic [31:0] ss_data;
  logic        ss_ready;
  logic        sm_valid;
  logic [31:0] sm_data;
  logic        sm_last;
  logic        sm_ready;
  logic        tap_we;
  logic        tap_re;
  logic [11:0] tap_waddr;
  logic [11:0] tap_raddr;
  logic [31:0] tap_wdi;
  logic [31:0] tap_rdo = '0;
  logic        data_we;
  logic        data_re;
  logic [11:0] data_waddr;
  logic [11:0] data_raddr;
  logic [31:0] data_wdi;
  logic [31:0] data_rdo = '0;

  logic [31:0] tapMem  [0:10] = '{default: 32'h0};
  logic [31:0] dataMem [0:10] = '{default: 32'hDEADBEEF};

  int          testsRun;
  int          testsFailed;
  logic [31:0] inSamples [0:15];
  logic [31:0] outVals   [0:15];
  logic        outLast   [0:15];
  int          outCount;
  int          doneCount;
  int          doneTick;
  int          validSeen;

  fir_tap_sched dut (
    .clk       (clk),
    .rst       (rst),
    .ap_start  (ap_start),
    .data_len  (data_len),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .cfg_we    (cfg_we),
    .cfg_re    (cfg_re),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .ss_valid  (ss_valid),
    .ss_data   (ss_data),
    .ss_ready  (ss_ready),
    .sm_valid  (sm_valid),
    .sm_data   (sm_data),
    .sm_last   (sm_last),
    .sm_ready  (sm_ready),
    .tap_we    (tap_we),
    .tap_re    (tap_re),
    .tap_waddr (tap_waddr),
    .tap_raddr (tap_raddr),
    .tap_wdi   (tap_wdi),
    .tap_rdo   (tap_rdo),
    .data_we   (data_we),
    .data_re   (data_re),
    .data_waddr(data_waddr),
    .data_raddr(data_raddr),
    .data_wdi  (data_wdi),
    .data_rdo  (data_rdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port-per-direction RAMs with one-cycle registered read.
  always @(posedge clk) begin
    if (tap_we && tap_waddr[11:2] < 10'd11) tapMem[tap_waddr[5:2]] <= tap_wdi;
    if (tap_re && tap_raddr[11:2] < 10'd11) tap_rdo <= tapMem[tap_raddr[5:2]];
    if (data_we && data_waddr[11:2] < 10'd11) dataMem[data_waddr[5:2]] <= data_wdi;
    if (data_re && data_raddr[11:2] < 10'd11) data_rdo <= dataMem[data_raddr[5:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tap(input int idx, input logic [31:0] val);
    cfg_we    = 1'b1;
    cfg_addr  = 12'(idx * 4);
    cfg_wdata = val;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Runs one job with full-speed streams, recording outputs and done timing.
  task automatic run_stream(input int n);
    int sent;
    int ticks;
    bit hsIn;
    sent      = 0;
    outCount  = 0;
    doneCount = 0;
    doneTick  = -1;
    validSeen = 0;
    sm_ready  = 1'b1;
    data_len  = 32'(n);
    ap_start  = 1'b1;
    tick();
    ticks     = 1;
    ap_start  = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (ss_ready && sent < n) begin
        ss_valid = 1'b1;
        ss_data  = inSamples[sent];
      end else begin
        ss_valid = 1'b0;
        ss_data  = '0;
      end
      hsIn = ss_valid && ss_ready;
      if (sm_valid) validSeen++;
      if (sm_valid && sm_ready && outCount < 16) begin
        outVals[outCount] = sm_data;
        outLast[outCount] = sm_last;
        outCount++;
      end
      tick();
      ticks++;
      if (hsIn) sent++;
      if (ap_done) begin
        doneCount++;
        if (doneTick < 0) doneTick = ticks;
      end
      if (doneTick >= 0 && ticks >= doneTick + 3) break;
    end
    ss_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    testsRun++;
    if (ap_idle !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ap_idle: got %b expected 1", ap_idle); end
    testsRun++;
    if ({ap_done, ss_ready, sm_valid, sm_last} !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 0000", {ap_done, ss_ready, sm_valid, sm_last});
    end
    testsRun++;
    if ({tap_we, tap_re, data_we, data_re} !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL reset_ram_en: got %b expected 0000", {tap_we, tap_re, data_we, data_re});
    end
    testsRun++;
    if (sm_data !== 32'd0 || cfg_rdata !== 32'd0) begin
      testsFailed++; $display("[TB] FAIL reset_data: got sm_data %0h cfg_rdata %0h expected 0 0", sm_data, cfg_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cfg();
    for (int i = 0; i < 11; i++) write_tap(i, 32'(i + 1));
    cfg_we    = 1'b1;
    cfg_addr  = 12'h02C;
    cfg_wdata = 32'h0000_0BAD;
    #1;
    testsRun++;
    if (tap_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL cfg_drop_write: tap_we %b expected 0", tap_we); end
    tick();
    cfg_we = 1'b0;
    cfg_re = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cfg_addr = 12'(i * 4);
      tick();
      testsRun++;
      if (cfg_rdata !== 32'(i + 1)) begin
        testsFailed++; $display("[TB] FAIL cfg_read[%0d]: got %0h expected %0h", i, cfg_rdata, i + 1);
      end
    end
    cfg_addr = 12'h02C;
    #1;
    testsRun++;
    if (tap_re !== 1'b0) begin testsFailed++; $display("[TB] FAIL cfg_drop_read: tap_re %b expected 0", tap_re); end
    tick();
    cfg_re = 1'b0;
    testsRun++;
    if (cfg_rdata !== 32'd0) begin testsFailed++; $display("[TB] FAIL cfg_drop_rdata: got %0h expected 0", cfg_rdata); end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 16; i++) inSamples[i] = (i == 0) ? 32'd1 : 32'd0;
    run_stream(11);
    testsRun++;
    if (outCount !== 11) begin testsFailed++; $display("[TB] FAIL impulse_count: got %0d expected 11", outCount); end
    for (int j = 0; j < 11 && j < outCount; j++) begin
      testsRun++;
      if (outVals[j] !== 32'(j + 1) || outLast[j] !== (j == 10)) begin
        testsFailed++;
        $display("[TB] FAIL impulse_out[%0d]: got %0d last %b expected %0d last %b", j, outVals[j], outLast[j], j + 1, j == 10);
      end
    end
    testsRun++;
    if (doneCount !== 1 || doneTick !== 12 + 14 * 11) begin
      testsFailed++; $display("[TB] FAIL impulse_done: got count %0d tick %0d expected 1 %0d", doneCount, doneTick, 12 + 14 * 11);
    end
  endtask

  task automatic test_step();
    logic [31:0] expVal;
    for (int i = 0; i < 11; i++) write_tap(i, 32'd1);
    for (int i = 0; i < 16; i++) inSamples[i] = 32'd1;
    for (int r = 0; r < 2; r++) begin
      run_stream(13);
      testsRun++;
      if (outCount !== 13 || doneTick !== 12 + 14 * 13) begin
        testsFailed++; $display("[TB] FAIL step_run%0d_len: got count %0d tick %0d expected 13 %0d", r, outCount, doneTick, 12 + 14 * 13);
      end
      for (int j = 0; j < 13 && j < outCount; j++) begin
        expVal = (j < 11) ? 32'(j + 1) : 32'd11;
        testsRun++;
        if (outVals[j] !== expVal || outLast[j] !== (j == 12)) begin
          testsFailed++;
          $display("[TB] FAIL step_run%0d_out[%0d]: got %0d last %b expected %0d last %b", r, j, outVals[j], outLast[j], expVal, j == 12);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 11; i++) write_tap(i, 32'd2);
    sm_ready = 1'b0;
    data_len = 32'd2;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int c = 0; c < 40 && !ss_ready; c++) tick();
    ss_valid = 1'b1;
    ss_data  = 32'd3;
    tick();
    ss_data  = 32'd1;
    for (int c = 0; c < 40 && !sm_valid; c++) tick();
    testsRun++;
    if (sm_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_valid_timeout: sm_valid %b expected 1", sm_valid); end
    cfg_we    = 1'b1;
    cfg_addr  = 12'h000;
    cfg_wdata = 32'd0;
    ap_start  = 1'b1;
    for (int h = 0; h < 5; h++) begin
      testsRun++;
      if (sm_valid !== 1'b1 || sm_data !== 32'd6 || ss_ready !== 1'b0 || sm_last !== 1'b0 || tap_we !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold[%0d]: got valid %b data %0d ss_ready %b last %b tap_we %b expected 1 6 0 0 0",
                 h, sm_valid, sm_data, ss_ready, sm_last, tap_we);
      end
      tick();
    end
    cfg_we   = 1'b0;
    ap_start = 1'b0;
    sm_ready = 1'b1;
    tick();
    for (int c = 0; c < 10 && !ss_ready; c++) tick();
    tick();
    ss_valid = 1'b0;
    for (int c = 0; c < 40 && !sm_valid; c++) tick();
    testsRun++;
    if (sm_valid !== 1'b1 || sm_data !== 32'd8 || sm_last !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL bp_second: got valid %b data %0d last %b expected 1 8 1", sm_valid, sm_data, sm_last);
    end
    doneCount = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ap_done) doneCount++;
    end
    testsRun++;
    if (doneCount !== 1 || ap_idle !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL bp_done: got done %0d idle %b expected 1 1", doneCount, ap_idle);
    end
  endtask

  task automatic test_overflow();
    write_tap(0, 32'h7FFF_FFFF);
    for (int i = 1; i < 11; i++) write_tap(i, 32'd0);
    inSamples[0] = 32'd2;
    run_stream(1);
    testsRun++;
    if (outCount !== 1 || outVals[0] !== 32'hFFFF_FFFE || outLast[0] !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL overflow: got count %0d data %0h last %b expected 1 fffffffe 1", outCount, outVals[0], outLast[0]);
    end
  endtask

  task automatic test_zero_len();
    run_stream(0);
    testsRun++;
    if (doneTick !== 12 || doneCount !== 1 || validSeen !== 0) begin
      testsFailed++; $display("[TB] FAIL zero_len: got tick %0d done %0d valid %0d expected 12 1 0", doneTick, doneCount, validSeen);
    end
  endtask

  task automatic test_reset_mid_run();
    data_len = 32'd1;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int c = 0; c < 40 && !ss_ready; c++) tick();
    ss_valid = 1'b1;
    ss_data  = 32'd5;
    tick();
    ss_valid = 1'b0;
    tick();
    tick();
    testsRun++;
    if (data_re !== 1'b1 || ap_idle !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL midrun_in_mac: got data_re %b idle %b expected 1 0", data_re, ap_idle);
    end
    rst = 1'b1;
    #2;
    testsRun++;
    if (ap_idle !== 1'b1 || {tap_re, data_re, data_we, ss_ready, sm_valid} !== 5'b00000) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset: got idle %b en %b expected 1 00000", ap_idle, {tap_re, data_re, data_we, ss_ready, sm_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    inSamples[0] = 32'd2;
    run_stream(1);
    testsRun++;
    if (outCount !== 1 || outVals[0] !== 32'hFFFF_FFFE || doneTick !== 26) begin
      testsFailed++; $display("[TB] FAIL midrun_rerun: got count %0d data %0h tick %0d expected 1 fffffffe 26", outCount, outVals[0], doneTick);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst       = 1'b1;
    ap_start  = 1'b0;
    data_len  = '0;
    cfg_we    = 1'b0;
    cfg_re    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    ss_valid  = 1'b0;
    ss_data   = '0;
    sm_ready  = 1'b0;
    test_reset();
    test_cfg();
    test_impulse();
    test_step();
    test_backpressure();
    test_overflow();
    test_zero_len();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
